pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
// PURPOSE
//  Command-driven duty controller in front of the PWM generator. Accepts duty/mode targets over a
//  valid/ready handshake and slews the applied duty toward the target, one step per PWM period.
//  Mode changes (960 Hz LED <-> 50 Hz servo) are sequenced: ramp to 0, switch mode, ramp to target.
//  duty_out/mode_out drive the PWM block's duty and mode-select inputs directly.
// PARAMETERS
//  DUTY_W   7    width of duty command and applied duty (matches PWM duty field)
//  STEP_W   3    width of per-period slew step
//  SW_GAP   2    full PWM periods held at duty 0 before mode_out toggles
// PORTS
//  clk         in   1        system clock
//  rst_n       in   1        reset, asynchronous, active-low
//  ena         in   1        enable; low freezes all state, cmd_ready=0
//  period_tick in   1        1-cycle pulse from PWM at start of each PWM period
//  cmd_valid   in   1        command valid
//  cmd_ready   out  1        command accepted when cmd_valid & cmd_ready
//  cmd_duty    in   DUTY_W   target duty
//  cmd_mode    in   1        target mode: 0 = LED 960 Hz, 1 = servo 50 Hz
//  cmd_step    in   STEP_W   slew per period; 0 is treated as 1
//  duty_out    out  DUTY_W   applied duty to PWM
//  mode_out    out  1        applied mode to PWM
//  busy        out  1        high in any state except IDLE/HOLD
//  done        out  1        1-cycle pulse when duty_out first equals target after a command
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): state=IDLE, duty_out=0, mode_out=0,
//   busy=0, done=0, target/step regs=0, gap counter=0. Reset mid-ramp aborts immediately.
//  FSM: IDLE, RAMP_DN, SWITCH, RAMP, HOLD.
//   cmd_ready = ena & (state==IDLE | state==HOLD). On accept, latch target, mode, step (0->1).
//   Accept, mode == mode_out          -> RAMP next cycle.
//   Accept, mode != mode_out          -> RAMP_DN next cycle.
//   RAMP_DN: on each period_tick, duty_out -= step, saturating at 0; when duty_out==0 -> SWITCH.
//   SWITCH: count SW_GAP period_ticks at duty 0; on the SW_GAP-th tick toggle mode_out -> RAMP.
//   RAMP: on each period_tick, if |target-duty_out| <= step then duty_out=target, pulse done
//    that cycle, -> HOLD; else duty_out moves toward target by step.
//   Accept with target == duty_out and same mode: RAMP exits on first period_tick, done pulses.
//   HOLD: outputs static; a new command retargets as from IDLE.
//  duty_out/mode_out change only in the cycle after period_tick (no mid-period glitches).
//  Arithmetic: unsigned DUTY_W+1 internal; no wrap past 0 or 2^DUTY_W-1.
//  period_tick coincident with accept: tick is not applied to new command (first step on next tick).
//  ena low: period_tick ignored, counters and FSM frozen, done held 0.
// CONFIGURATION
//  PWM_SEQ_CLAMP_EN defined: in servo mode (target mode=1) latched target clamped to
//   [SERVO_MIN, SERVO_MAX] = [5, 10]; LED mode unclamped.
//  Not defined: target latched verbatim in both modes.
// STRUCTURE
//  pwm_pkg (shared include): FSM state encodings, SERVO_MIN/SERVO_MAX, MODE_LED/MODE_SERVO.
//  Sub-module pwm_seq_stepper: combinational saturating move of cur toward tgt by step,
//   outputs next value and arrived flag; used by RAMP and RAMP_DN (tgt=0).
// TESTING
//  Reset: rst_n=0 mid-RAMP -> duty_out=0, mode_out=0, busy=0, cmd_ready=1 same cycle after release.
//  LED ramp: cmd duty=20 mode=0 step=4 -> duty_out 4,8,12,16,20 on successive ticks; done on 5th.
//  Non-multiple: duty_out=20, cmd duty=3 step=7 -> 13,6,3; done with 3rd update, HOLD.
//  Mode change: duty_out=12 mode=0, cmd duty=8 mode=1 step=5 -> 7,2,0; 2 ticks at 0; mode_out=1;
//   then 5,8; done.
//  Step 0 / equal target: cmd duty=duty_out step=0 -> no duty change, done on first tick.
//  Clamp (PWM_SEQ_CLAMP_EN): cmd duty=60 mode=1 -> settles at 10; without macro settles at 60.

Source files
------------

// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared definitions for the PWM duty sequencer: default widths, FSM states,
// mode encodings and the servo duty window used when target clamping is built in.
package pwm_duty_sequencer_pkg;

  localparam int unsigned DUTY_W_DEF = 7;
  localparam int unsigned STEP_W_DEF = 3;
  localparam int unsigned SW_GAP_DEF = 2;

  // Servo duty window applied to servo-mode targets when PWM_SEQ_CLAMP_EN is defined
  localparam int unsigned SERVO_MIN = 5;
  localparam int unsigned SERVO_MAX = 10;

  localparam logic MODE_LED   = 1'b0;
  localparam logic MODE_SERVO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAMP_DN = 3'd1,
    ST_SWITCH  = 3'd2,
    ST_RAMP    = 3'd3,
    ST_HOLD    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Command channel of the duty sequencer (valid/ready handshake plus payload).
//   cmd_valid  master->slave  command valid
//   cmd_ready  slave->master  command accepted when cmd_valid & cmd_ready
//   cmd_duty   master->slave  target duty
//   cmd_mode   master->slave  target mode (0 LED, 1 servo)
//   cmd_step   master->slave  slew per PWM period (0 means 1)
interface pwm_duty_sequencer_if #(
  parameter int unsigned DUTY_W = 7,
  parameter int unsigned STEP_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_mode;
  logic [STEP_W-1:0] cmd_step;

  modport master (output cmd_valid, cmd_duty, cmd_mode, cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, cmd_duty, cmd_mode, cmd_step, output cmd_ready);
endinterface

// File: rtl/pwm_duty_sequencer_stepper.sv
// pwm_seq_stepper: combinational saturating move of cur toward tgt by step.
//   cur, tgt   current and target duty
//   step       slew amount (caller guarantees nonzero)
//   next_c     cur moved toward tgt, landing exactly on tgt when within step
//   arrived_c  |tgt - cur| <= step
module pwm_seq_stepper #(
  parameter int unsigned DUTY_W = 7,
  parameter int unsigned STEP_W = 3
) (
  input  logic [DUTY_W-1:0] cur,
  input  logic [DUTY_W-1:0] tgt,
  input  logic [STEP_W-1:0] step,
  output logic [DUTY_W-1:0] next_c,
  output logic              arrived_c
);
  localparam int unsigned AW = DUTY_W + 1;

  logic [AW-1:0] cur_w;
  logic [AW-1:0] tgt_w;
  logic [AW-1:0] step_w;
  logic [AW-1:0] diff;

  // One guard bit; landing on tgt when within step means no wrap past either end
  always_comb begin
    cur_w     = AW'(cur);
    tgt_w     = AW'(tgt);
    step_w    = AW'(step);
    diff      = (cur_w >= tgt_w) ? (cur_w - tgt_w) : (tgt_w - cur_w);
    arrived_c = (diff <= step_w);
    next_c    = tgt;
    if (!arrived_c) begin
      if (cur_w > tgt_w) next_c = DUTY_W'(cur_w - step_w);
      else               next_c = DUTY_W'(cur_w + step_w);
    end
  end
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: accepts duty/mode commands and slews the applied duty toward
// the target one step per PWM period; a mode change ramps to 0, holds SW_GAP
// periods at 0, flips mode, then ramps to the target.
// Optional build macro PWM_SEQ_CLAMP_EN: clamp servo-mode targets to [SERVO_MIN, SERVO_MAX].
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          enable; low freezes all state and drops cmd_ready
//   period_tick  1-cycle pulse at the start of each PWM period
//   cmd          command channel (slave side)
//   duty_out     applied duty to the PWM
//   mode_out     applied mode to the PWM
//   busy         high outside IDLE/HOLD
//   done         1-cycle pulse when duty_out reaches the target
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int unsigned DUTY_W = DUTY_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned SW_GAP = SW_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              period_tick,
  pwm_duty_sequencer_if.slave cmd,
  output logic [DUTY_W-1:0] duty_out,
  output logic              mode_out,
  output logic              busy,
  output logic              done
);
  localparam int unsigned GAP_W = (SW_GAP > 1) ? $clog2(SW_GAP) : 1;

  seq_state_e        state_q, state_n;
  logic [DUTY_W-1:0] target_q, target_n;
  logic              tmode_q, tmode_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [GAP_W-1:0]  gap_q, gap_n;
  logic [DUTY_W-1:0] duty_n;
  logic              mode_n;
  logic              done_n;
  logic [DUTY_W-1:0] step_tgt;
  logic [DUTY_W-1:0] step_next_c;
  logic              step_arrived_c;

  assign cmd.cmd_ready = ena & ((state_q == ST_IDLE) | (state_q == ST_HOLD));

  // Ramp-down heads for 0; ramp-up heads for the latched target
  assign step_tgt = (state_q == ST_RAMP_DN) ? '0 : target_q;

  pwm_seq_stepper #(
    .DUTY_W (DUTY_W),
    .STEP_W (STEP_W)
  ) u_stepper (
    .cur       (duty_out),
    .tgt       (step_tgt),
    .step      (step_q),
    .next_c    (step_next_c),
    .arrived_c (step_arrived_c)
  );

  // Next-state and next-output logic; everything holds while ena is low
  always_comb begin
    state_n  = state_q;
    target_n = target_q;
    tmode_n  = tmode_q;
    step_n   = step_q;
    gap_n    = gap_q;
    duty_n   = duty_out;
    mode_n   = mode_out;
    done_n   = 1'b0;
    if (ena) begin
      unique case (state_q)
        ST_IDLE, ST_HOLD: begin
          // A tick in the accept cycle is deliberately not applied to the new command
          if (cmd.cmd_valid) begin
`ifdef PWM_SEQ_CLAMP_EN
            target_n = cmd.cmd_duty;
            if (cmd.cmd_mode == MODE_SERVO) begin
              if (cmd.cmd_duty < DUTY_W'(SERVO_MIN))      target_n = DUTY_W'(SERVO_MIN);
              else if (cmd.cmd_duty > DUTY_W'(SERVO_MAX)) target_n = DUTY_W'(SERVO_MAX);
            end
`else
            target_n = cmd.cmd_duty;
`endif
            tmode_n = cmd.cmd_mode;
            step_n  = (cmd.cmd_step == '0) ? STEP_W'(1) : cmd.cmd_step;
            gap_n   = '0;
            state_n = (cmd.cmd_mode == mode_out) ? ST_RAMP : ST_RAMP_DN;
          end
        end
        ST_RAMP_DN: begin
          if (period_tick) begin
            duty_n = step_next_c;
            if (step_arrived_c) state_n = ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (period_tick) begin
            if (gap_q == GAP_W'(SW_GAP - 1)) begin
              gap_n   = '0;
              mode_n  = tmode_q;
              state_n = ST_RAMP;
            end else begin
              gap_n = gap_q + GAP_W'(1);
            end
          end
        end
        ST_RAMP: begin
          if (period_tick) begin
            duty_n = step_next_c;
            if (step_arrived_c) begin
              done_n  = 1'b1;
              state_n = ST_HOLD;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      tmode_q  <= MODE_LED;
      step_q   <= '0;
      gap_q    <= '0;
      duty_out <= '0;
      mode_out <= MODE_LED;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      target_q <= target_n;
      tmode_q  <= tmode_n;
      step_q   <= step_n;
      gap_q    <= gap_n;
      duty_out <= duty_n;
      mode_out <= mode_n;
      busy     <= (state_n != ST_IDLE) && (state_n != ST_HOLD);
      done     <= done_n;
    end
  end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: every command pushes the sequence of
// observable (duty, mode, done) updates it should produce; a monitor pops one
// entry each time the outputs change or done pulses.
module tb_pwm_duty_sequencer;
  localparam int unsigned DW = 7;
  localparam int unsigned SW = 3;
  localparam int WAIT_LIMIT = 5000;

  typedef struct {
    int duty;
    int mode;
    int done;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          period_tick;
  logic [DW-1:0] duty_out;
  logic          mode_out;
  logic          busy;
  logic          done;

  pwm_duty_sequencer_if #(.DUTY_W(DW), .STEP_W(SW)) cmd_if ();

  pwm_duty_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .period_tick (period_tick),
    .cmd         (cmd_if),
    .duty_out    (duty_out),
    .mode_out    (mode_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  duty_m = 0;
  int  mode_m = 0;
  bit  mon_en = 1'b0;
  bit  tick_en = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_ev(input int d, input int m, input int dn);
    exp_q.push_back('{duty: d, mode: m, done: dn});
  endtask

  // Reference model: walk the command's rules with plain arithmetic
  task automatic model_cmd(input int d, input int m, input int s);
    int tgt;
    int se;
    int diff;
    tgt = d;
    se  = (s == 0) ? 1 : s;
`ifdef PWM_SEQ_CLAMP_EN
    if (m == 1) begin
      if (tgt < 5)  tgt = 5;
      if (tgt > 10) tgt = 10;
    end
`endif
    if (m != mode_m) begin
      while (duty_m > 0) begin
        duty_m = (duty_m > se) ? duty_m - se : 0;
        push_ev(duty_m, mode_m, 0);
      end
      mode_m = m;
      push_ev(0, m, 0);
    end
    forever begin
      diff = tgt - duty_m;
      if (diff < 0) diff = -diff;
      if (diff <= se) begin
        duty_m = tgt;
        push_ev(tgt, m, 1);
        break;
      end
      duty_m = (tgt > duty_m) ? duty_m + se : duty_m - se;
      push_ev(duty_m, m, 0);
    end
  endtask

  // Present a command and hold it until the DUT takes it
  task automatic send(input int d, input int m, input int s);
    int n;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = DW'(d);
    cmd_if.cmd_mode  = 1'(m);
    cmd_if.cmd_step  = SW'(s);
    n = 0;
    forever begin
      @(posedge clk);
      if (cmd_if.cmd_ready) break;
      n++;
      if (n >= WAIT_LIMIT) break;
    end
    if (n >= WAIT_LIMIT) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got no cmd_ready expected accept within %0d cycles", WAIT_LIMIT);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Wait until every expected update has been observed
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending updates expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Random PWM period ticks and enable gaps
  initial begin
    forever begin
      @(negedge clk);
      if (tick_en) begin
        period_tick = ($urandom_range(0, 3) == 0);
        ena         = ($urandom_range(0, 9) != 0);
      end else begin
        period_tick = 1'b0;
        ena         = 1'b1;
      end
    end
  end

  // Monitor: any output change or done pulse consumes one expected update
  initial begin
    int  last_duty;
    int  last_mode;
    bit  t;
    ev_t e;
    last_duty = 0;
    last_mode = 0;
    forever begin
      @(posedge clk);
      t = period_tick & ena;
      #1;
      if (mon_en && (int'(duty_out) != last_duty || int'(mode_out) != last_mode || done)) begin
        check("update_after_tick", int'(t), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got duty=%0d mode=%0d done=%0d expected no update",
                   duty_out, mode_out, done);
        end else begin
          e = exp_q.pop_front();
          check("duty_out", int'(duty_out), e.duty);
          check("mode_out", int'(mode_out), e.mode);
          check("done", int'(done), e.done);
          if (done) check("busy_at_done", int'(busy), 0);
        end
      end
      last_duty = int'(duty_out);
      last_mode = int'(mode_out);
    end
  end

  initial begin
    int d;
    int m;
    int s;
    rst_n            = 1'b0;
    ena              = 1'b1;
    period_tick      = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_duty  = '0;
    cmd_if.cmd_mode  = 1'b0;
    cmd_if.cmd_step  = '0;
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty_out), 0);
    check("rst_mode", int'(mode_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cmd_ready", int'(cmd_if.cmd_ready), 1);
    rst_n = 1'b1;
    mon_en  = 1'b1;
    tick_en = 1'b1;

    // LED ramp 0 -> 20 by 4
    push_ev(4, 0, 0); push_ev(8, 0, 0); push_ev(12, 0, 0); push_ev(16, 0, 0); push_ev(20, 0, 1);
    send(20, 0, 4);
    wait_drain("led_ramp");
    check("led_ramp_hold_busy", int'(busy), 0);

    // Non-multiple step down 20 -> 3 by 7
    push_ev(13, 0, 0); push_ev(6, 0, 0); push_ev(3, 0, 1);
    send(3, 0, 7);
    wait_drain("non_multiple");

    push_ev(10, 0, 0); push_ev(12, 0, 1);
    send(12, 0, 7);
    wait_drain("to_12");

    // Mode change LED -> servo with ramp through 0
    push_ev(7, 0, 0); push_ev(2, 0, 0); push_ev(0, 0, 0); push_ev(0, 1, 0);
    push_ev(5, 1, 0); push_ev(8, 1, 1);
    send(8, 1, 5);
    wait_drain("mode_change");
    duty_m = 8;
    mode_m = 1;

    // Equal target with step 0: done on first tick, no duty change
    push_ev(8, 1, 1);
    send(8, 1, 0);
    wait_drain("equal_target");

    // Servo target outside the servo window
    model_cmd(60, 1, 7);
    send(60, 1, 7);
    wait_drain("clamp");
`ifdef PWM_SEQ_CLAMP_EN
    check("clamp_settle", int'(duty_out), 10);
`else
    check("clamp_settle", int'(duty_out), 60);
`endif

    // Randomised commands against the reference model
    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 127));
      m = ($urandom_range(0, 3) == 0) ? 1 - mode_m : mode_m;
      s = int'($urandom_range(0, 7));
      model_cmd(d, m, s);
      send(d, m, s);
      wait_drain("random");
    end

    // Reset in the middle of a long ramp
    d = (duty_m >= 64) ? 0 : 127;
    model_cmd(d, mode_m, 1);
    send(d, mode_m, 1);
    repeat (20) @(negedge clk);
    check("mid_ramp_busy", int'(busy), 1);
    tick_en = 1'b0;
    mon_en  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_duty", int'(duty_out), 0);
    check("abort_mode", int'(mode_out), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    duty_m = 0;
    mode_m = 0;
    #1;
    check("post_rst_cmd_ready", int'(cmd_if.cmd_ready), 1);
    check("post_rst_duty", int'(duty_out), 0);
    check("post_rst_done", int'(done), 0);
    mon_en  = 1'b1;
    tick_en = 1'b1;

    model_cmd(30, 0, 3);
    send(30, 0, 3);
    wait_drain("post_reset");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
